mult_8x8_seq_ctrl: RTL
======================

# mult_8x8_seq_ctrl

Sequential, configurable-approximation 8x8 unsigned multiplier controller. It time-multiplexes one internal 4x4 partial-product unit across the four nibble quadrants of an 8x8 product, applies a per-quadrant approximation mode, and accumulates the result. It sits between a valid/ready operand source and a valid/ready result sink. It is the area-lean, runtime-configurable counterpart of the fixed four-multiplier 8x8 approximate arrays in the library.

## Interface
- MODE_EN, default 1: 1 = honor `cfg_mode`; 0 = force all quadrants exact (mode 00).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/config valid
- in_ready  out  1  block can accept operands
- a  in  8  multiplicand, unsigned
- b  in  8  multiplier, unsigned
- cfg_mode  in  8  per-quadrant mode: [1:0]=Q0, [3:2]=Q1, [5:4]=Q2, [7:6]=Q3
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- r  out  16  product
- busy  out  1  high whenever state is not IDLE
- op_cnt  out  16  completed-result counter, wraps 0xFFFF -> 0x0000

## Operation
- Reset is asynchronous and active-low. Values while `rst_n` is low:
  - `in_ready`=0, `out_valid`=0, `r`=0, `busy`=0, `op_cnt`=0
  - state = IDLE, accumulator = 0, quadrant counter = 0
  - `in_ready` rises in the first cycle after `rst_n` deasserts.
- States:
  - IDLE: `in_ready`=1. On `in_valid` && `in_ready`, latch `a`, `b` and `cfg_mode` (or 0x00 if MODE_EN=0), clear the accumulator and counter, and go to CALC.
  - CALC: one quadrant per cycle, counter 0..3. After quadrant 3 go to DONE.
  - DONE: `out_valid`=1 and `r` = accumulator. On `out_ready`, increment `op_cnt` and return to IDLE.
- Quadrants (aL=a[3:0], aH=a[7:4], bL=b[3:0], bH=b[7:4]):
  - Q0 = aL*bL, shift 0
  - Q1 = aL*bH, shift 4
  - Q2 = aH*bL, shift 4
  - Q3 = aH*bH, shift 8
- Partial product pp is 8 bits exact. Mode is applied before shifting:
  - 00: pp unchanged
  - 01: pp & 0xFC
  - 10: pp & 0xF0
  - 11: pp = 0 (quadrant skipped; still takes its cycle)
- Accumulator is 16 bits. The sum never exceeds 65025, so no overflow handling is needed.
- `r` holds its value through DONE. `r` updates only on entry to DONE, and holds the last result in IDLE and CALC.
- Inputs are ignored outside IDLE. `in_ready`=0 there, so `a`, `b` and `cfg_mode` may change freely.

## Timing
- Let E0 be the accept edge. Quadrants Q0..Q3 accumulate on edges E1..E4.
  - `out_valid` is high from E4 onward.
  - Earliest result handshake is at E5.
  - Earliest next accept is at E6, since `in_ready` returns after E5.
  - Maximum throughput is one result per 6 cycles.
- Latency is fixed at 4 cycles regardless of operands or modes.
- Backpressure: while `out_ready`=0 in DONE, `out_valid`, `r` and `op_cnt` are stable and `in_ready`=0.
- `busy` is high from the cycle after E0 through the cycle of the result handshake.
- `op_cnt` increments on the handshake edge itself (same edge that `out_valid` falls).
- Reset mid-CALC or mid-DONE:
  - Immediate return to IDLE with the reset values above.
  - The partial result is discarded and `op_cnt` is not incremented.
- `in_valid` held high continuously means back-to-back operations, each accepted on the first IDLE cycle.

## Test plan
- a=0xFF, b=0xFF, cfg=0x00 -> `r`=65025 (0xFE01), `out_valid` exactly 4 edges after accept, `op_cnt`=1 after handshake.
- a=0x0F, b=0x0F, cfg=0x02 (Q0 mode 10) -> `r`=224. Repeat with MODE_EN=0 -> `r`=225.
- a=0xF0, b=0xF0, cfg=0x40 (Q3 mode 01) -> `r`=57344. Same with cfg=0x00 -> 57600. Same with cfg=0xFF -> 0.
- a=0x12, b=0x34, cfg=0x00, with `out_ready` low for 3 cycles after `out_valid` -> `r`=0x03A8 stable, `in_ready`=0 and `busy`=1 throughout, `op_cnt` increments once on release.
- Assert `rst_n` low during CALC cycle 2 of a=0xFF, b=0xFF -> all outputs at reset values. Next op a=3, b=5 -> `r`=15, `op_cnt`=1.
- 65536 back-to-back ops with `in_valid`/`out_ready` tied high -> 6-cycle spacing, `op_cnt` wraps to 0x0000.

Source files
------------

// File: rtl/mult_8x8_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier controller.
// The master side is the operand source plus the result sink; the slave side is the controller.
interface mult_8x8_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [7:0]  cfg_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] r;
   logic        busy;
   logic [15:0] op_cnt;

   modport master (
      output in_valid, a, b, cfg_mode, out_ready,
      input  in_ready, out_valid, r, busy, op_cnt
   );

   modport slave (
      input  in_valid, a, b, cfg_mode, out_ready,
      output in_ready, out_valid, r, busy, op_cnt
   );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential configurable-approximation 8x8 unsigned multiplier.
// One 4x4 partial-product unit is reused across the four nibble quadrants,
// one quadrant per cycle, with a per-quadrant truncation mode.
module mult_8x8_seq_ctrl #(
   parameter bit MODE_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mult_8x8_seq_ctrl_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [7:0]  mode_q;
   logic [15:0] acc;
   logic [1:0]  qcnt;

   logic [3:0]  an;
   logic [3:0]  bn;
   logic [1:0]  qmode;
   logic [7:0]  pp_raw;
   logic [7:0]  pp;
   logic [15:0] pp_sh;
   logic [15:0] acc_nxt;

   // Quadrant datapath: counter bit 1 picks the high nibble of a, bit 0 the high nibble of b.
   always_comb begin
      an     = qcnt[1] ? a_q[7:4] : a_q[3:0];
      bn     = qcnt[0] ? b_q[7:4] : b_q[3:0];
      pp_raw = {4'b0000, an} * {4'b0000, bn};
      qmode  = 2'b00;
      case (qcnt)
         2'd0:    qmode = mode_q[1:0];
         2'd1:    qmode = mode_q[3:2];
         2'd2:    qmode = mode_q[5:4];
         default: qmode = mode_q[7:6];
      endcase
      pp = pp_raw;
      case (qmode)
         2'b01:   pp = pp_raw & 8'hFC;
         2'b10:   pp = pp_raw & 8'hF0;
         2'b11:   pp = '0;
         default: pp = pp_raw;
      endcase
      pp_sh = '0;
      case (qcnt)
         2'd0:    pp_sh = {8'h00, pp};
         2'd1,
         2'd2:    pp_sh = {4'h0, pp, 4'h0};
         default: pp_sh = {pp, 8'h00};
      endcase
      acc_nxt = acc + pp_sh;
   end

   // Control FSM with registered handshake, status and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         mode_q        <= '0;
         acc           <= '0;
         qcnt          <= '0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.r         <= '0;
         bus.busy      <= 1'b0;
         bus.op_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.in_ready <= 1'b1;
               if (bus.in_valid && bus.in_ready) begin
                  a_q          <= bus.a;
                  b_q          <= bus.b;
                  mode_q       <= MODE_EN ? bus.cfg_mode : 8'h00;
                  acc          <= '0;
                  qcnt         <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  state        <= CALC;
               end
            end
            CALC: begin
               acc  <= acc_nxt;
               qcnt <= qcnt + 2'd1;
               if (qcnt == 2'd3) begin
                  // Result is taken from the adder so it lands together with out_valid.
                  bus.r         <= acc_nxt;
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.op_cnt    <= bus.op_cnt + 16'd1;
                  bus.busy      <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
